// File: rtl/cpu_fetch_decode_alu.sv
// Front half of the single-cycle 16-bit CPU: the fetch sequencer (PC and
// IDLE/RUN/HALTED control), the 9-bit instruction decoder and the ALU.
// The register file, data RAM and instruction memory live outside this block.
module cpu_fetch_decode_alu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic [8:0]  imem_data,
    input  logic [15:0] read_data0,
    input  logic [15:0] read_data1,
    input  logic [15:0] target,
    output logic [15:0] pc_out,
    output logic [8:0]  instr,
    output logic        start,
    output logic        branch,
    output logic        jump_sign,
    output logic        write,
    output logic        move,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        immediate,
    output logic [3:0]  read_reg0,
    output logic [3:0]  read_reg1,
    output logic [3:0]  write_reg,
    output logic [3:0]  alu_op,
    output logic [1:0]  reg_to_mem,
    output logic [1:0]  quarter,
    output logic [15:0] result,
    output logic [15:0] taken,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_SLT   = 4'd4,
        ALU_PASSA = 4'd5,
        ALU_PASSB = 4'd6,
        ALU_CMPZ  = 4'd7,
        ALU_CMPNZ = 4'd8
    } alu_e;

    state_e      state_q;
    state_e      state_d;
    logic        running;
    logic        halt;
    logic [2:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] next_pc;

    assign running = (state_q == RUN);

    // Only the instruction being executed is exposed; zero outside RUN.
    assign instr = running ? imem_data : '0;
    assign op    = instr[8:6];
    assign ra    = instr[5:3];
    assign rb    = instr[2:0];

    // Branch to R7 on an unconditional jump or a satisfied compare, else step.
    assign next_pc = (branch && (jump_sign || taken[0])) ? target : pc_out + 16'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: init only matters in IDLE, HALTED is left only by reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init) state_d = RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // PC sequencing plus the start pulse and sticky done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out <= RESET_PC;
            start  <= 1'b0;
            done   <= 1'b0;
        end else begin
            start <= (state_q == IDLE) && init;
            if ((state_q == IDLE) && init) begin
                pc_out <= RESET_PC;
            end else if (running && !halt) begin
                pc_out <= next_pc;
            end
            if (running && halt) begin
                done <= 1'b1;
            end
        end
    end

    // Instruction decode; every control stays 0 unless running.
    always_comb begin
        branch     = 1'b0;
        jump_sign  = 1'b0;
        write      = 1'b0;
        move       = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        immediate  = 1'b0;
        read_reg0  = '0;
        read_reg1  = '0;
        write_reg  = '0;
        alu_op     = '0;
        reg_to_mem = '0;
        quarter    = '0;
        halt       = 1'b0;
        if (running) begin
            case (op)
                3'b101: begin
                    read_reg1 = {1'b0, rb};
                    alu_op    = ALU_PASSB;
                    if (!instr[5]) begin
                        mem_to_reg = 1'b1;
                        write      = 1'b1;
                        write_reg  = {2'b00, instr[4:3]};
                    end else begin
                        mem_write  = 1'b1;
                        reg_to_mem = instr[4:3];
                    end
                end
                3'b110: begin
                    immediate = 1'b1;
                    write     = 1'b1;
                    quarter   = instr[5:4];
                    read_reg1 = instr[3:0];
                end
                3'b111: begin
                    case (ra)
                        3'b000: halt = 1'b1;
                        3'b001: begin
                            move      = 1'b1;
                            write     = 1'b1;
                            write_reg = {1'b0, rb};
                            alu_op    = ALU_PASSA;
                        end
                        3'b010: begin
                            branch    = 1'b1;
                            read_reg0 = {1'b0, rb};
                            read_reg1 = 4'd7;
                            alu_op    = ALU_CMPZ;
                        end
                        3'b011: begin
                            branch    = 1'b1;
                            read_reg0 = {1'b0, rb};
                            read_reg1 = 4'd7;
                            alu_op    = ALU_CMPNZ;
                        end
                        3'b100: begin
                            branch    = 1'b1;
                            jump_sign = 1'b1;
                            read_reg1 = 4'd7;
                        end
                        default: ;
                    endcase
                end
                // 000..100: register-register ALU ops, opcode doubles as alu_op.
                default: begin
                    read_reg0 = {1'b0, ra};
                    read_reg1 = {1'b0, rb};
                    write     = 1'b1;
                    write_reg = {1'b0, ra};
                    alu_op    = {1'b0, op};
                end
            endcase
        end
    end

    // ALU: compares drive only taken, everything else only result.
    always_comb begin
        result = '0;
        taken  = '0;
        case (alu_op)
            ALU_ADD:   result = read_data0 + read_data1;
            ALU_SUB:   result = read_data0 - read_data1;
            ALU_AND:   result = read_data0 & read_data1;
            ALU_OR:    result = read_data0 | read_data1;
            ALU_SLT:   result = {15'b0, $signed(read_data0) < $signed(read_data1)};
            ALU_PASSA: result = read_data0;
            ALU_PASSB: result = read_data1;
            ALU_CMPZ:  taken  = {15'b0, read_data0 == 16'h0000};
            ALU_CMPNZ: taken  = {15'b0, read_data0 != 16'h0000};
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_cpu_fetch_decode_alu.sv
// Scoreboard bench for cpu_fetch_decode_alu: the stimulus thread drives
// directed instructions and queues hand-computed expectations; a monitor
// drains the queue at every falling edge and compares against the DUT.
module tb_cpu_fetch_decode_alu;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic [8:0]  imem_data;
    logic [15:0] read_data0;
    logic [15:0] read_data1;
    logic [15:0] target;
    logic [15:0] pc_out;
    logic [8:0]  instr;
    logic        start;
    logic        branch;
    logic        jump_sign;
    logic        write;
    logic        move;
    logic        mem_to_reg;
    logic        mem_write;
    logic        immediate;
    logic [3:0]  read_reg0;
    logic [3:0]  read_reg1;
    logic [3:0]  write_reg;
    logic [3:0]  alu_op;
    logic [1:0]  reg_to_mem;
    logic [1:0]  quarter;
    logic [15:0] result;
    logic [15:0] taken;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef enum int {
        S_PC, S_INSTR, S_START, S_BRANCH, S_JSIGN, S_WRITE, S_MOVE, S_M2R,
        S_MWRITE, S_IMM, S_RR0, S_RR1, S_WR, S_ALUOP, S_R2M, S_QUARTER,
        S_RESULT, S_TAKEN, S_DONE
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] exp;
    } chk_t;

    chk_t q[$];

    cpu_fetch_decode_alu #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .imem_data(imem_data),
        .read_data0(read_data0), .read_data1(read_data1), .target(target),
        .pc_out(pc_out), .instr(instr), .start(start), .branch(branch),
        .jump_sign(jump_sign), .write(write), .move(move),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .immediate(immediate),
        .read_reg0(read_reg0), .read_reg1(read_reg1), .write_reg(write_reg),
        .alu_op(alu_op), .reg_to_mem(reg_to_mem), .quarter(quarter),
        .result(result), .taken(taken), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] read_sig(sig_e s);
        case (s)
            S_PC:      return pc_out;
            S_INSTR:   return {7'b0, instr};
            S_START:   return {15'b0, start};
            S_BRANCH:  return {15'b0, branch};
            S_JSIGN:   return {15'b0, jump_sign};
            S_WRITE:   return {15'b0, write};
            S_MOVE:    return {15'b0, move};
            S_M2R:     return {15'b0, mem_to_reg};
            S_MWRITE:  return {15'b0, mem_write};
            S_IMM:     return {15'b0, immediate};
            S_RR0:     return {12'b0, read_reg0};
            S_RR1:     return {12'b0, read_reg1};
            S_WR:      return {12'b0, write_reg};
            S_ALUOP:   return {12'b0, alu_op};
            S_R2M:     return {14'b0, reg_to_mem};
            S_QUARTER: return {14'b0, quarter};
            S_RESULT:  return result;
            S_TAKEN:   return taken;
            default:   return {15'b0, done};
        endcase
    endfunction

    task automatic expect_sig(string n, sig_e s, logic [15:0] v);
        chk_t c;
        c.name = n;
        c.sig  = s;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_quiet(string tag);
        expect_sig({tag, "_instr"},  S_INSTR,  16'h0000);
        expect_sig({tag, "_write"},  S_WRITE,  16'h0000);
        expect_sig({tag, "_branch"}, S_BRANCH, 16'h0000);
        expect_sig({tag, "_mwrite"}, S_MWRITE, 16'h0000);
        expect_sig({tag, "_imm"},    S_IMM,    16'h0000);
        expect_sig({tag, "_rr0"},    S_RR0,    16'h0000);
        expect_sig({tag, "_rr1"},    S_RR1,    16'h0000);
        expect_sig({tag, "_wr"},     S_WR,     16'h0000);
        expect_sig({tag, "_aluop"},  S_ALUOP,  16'h0000);
    endtask

    // Monitor: every falling edge, compare all pending expectations.
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = read_sig(c.sig);
                checks++;
                if (act !== c.exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Stimulus.
    initial begin
        rst_n      = 1'b0;
        init       = 1'b0;
        imem_data  = 9'b000_001_010;
        read_data0 = '0;
        read_data1 = '0;
        target     = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();

        // IDLE after reset: everything quiet even with an instruction present.
        expect_quiet("idle");
        expect_sig("idle_pc",    S_PC,    16'h0000);
        expect_sig("idle_start", S_START, 16'h0000);
        expect_sig("idle_done",  S_DONE,  16'h0000);
        init = 1'b1;
        cyc();

        // First RUN cycle, pc 0: ADD R1,R2 with 7FFF + 0002.
        init       = 1'b0;
        read_data0 = 16'h7FFF;
        read_data1 = 16'h0002;
        expect_sig("add_start",  S_START,  16'h0001);
        expect_sig("add_pc",     S_PC,     16'h0000);
        expect_sig("add_instr",  S_INSTR,  16'h000A);
        expect_sig("add_rr0",    S_RR0,    16'h0001);
        expect_sig("add_rr1",    S_RR1,    16'h0002);
        expect_sig("add_wr",     S_WR,     16'h0001);
        expect_sig("add_write",  S_WRITE,  16'h0001);
        expect_sig("add_aluop",  S_ALUOP,  16'h0000);
        expect_sig("add_result", S_RESULT, 16'h8001);
        cyc();

        // pc 1: SUB R0,R1 with 0000 - 0001.
        imem_data  = 9'b001_000_001;
        read_data0 = 16'h0000;
        read_data1 = 16'h0001;
        expect_sig("sub_start",  S_START,  16'h0000);
        expect_sig("sub_pc",     S_PC,     16'h0001);
        expect_sig("sub_aluop",  S_ALUOP,  16'h0001);
        expect_sig("sub_result", S_RESULT, 16'hFFFF);
        cyc();

        // pc 2: SLT signed, 8000 (negative) < 0001.
        imem_data  = 9'b100_000_001;
        read_data0 = 16'h8000;
        read_data1 = 16'h0001;
        expect_sig("slt_pc",     S_PC,     16'h0002);
        expect_sig("slt_result", S_RESULT, 16'h0001);
        cyc();

        // pc 3: BEQZ R3 taken to 0040.
        imem_data  = 9'b111_010_011;
        read_data0 = 16'h0000;
        target     = 16'h0040;
        expect_sig("beqz_pc",     S_PC,     16'h0003);
        expect_sig("beqz_branch", S_BRANCH, 16'h0001);
        expect_sig("beqz_jsign",  S_JSIGN,  16'h0000);
        expect_sig("beqz_rr0",    S_RR0,    16'h0003);
        expect_sig("beqz_rr1",    S_RR1,    16'h0007);
        expect_sig("beqz_aluop",  S_ALUOP,  16'h0007);
        expect_sig("beqz_taken",  S_TAKEN,  16'h0001);
        expect_sig("beqz_result", S_RESULT, 16'h0000);
        expect_sig("beqz_write",  S_WRITE,  16'h0000);
        cyc();

        // pc 0040: BEQZ not taken (A=5).
        read_data0 = 16'h0005;
        expect_sig("beqz_tgt_pc", S_PC,    16'h0040);
        expect_sig("beqz_nt",     S_TAKEN, 16'h0000);
        cyc();

        // pc 0041: JMP to 1234 regardless of A.
        imem_data = 9'b111_100_000;
        target    = 16'h1234;
        expect_sig("beqz_nt_pc", S_PC,     16'h0041);
        expect_sig("jmp_branch", S_BRANCH, 16'h0001);
        expect_sig("jmp_jsign",  S_JSIGN,  16'h0001);
        expect_sig("jmp_rr1",    S_RR1,    16'h0007);
        expect_sig("jmp_taken",  S_TAKEN,  16'h0000);
        cyc();

        // pc 1234: ST R5 -> mem, store data from R2.
        imem_data  = 9'b101_1_10_101;
        read_data1 = 16'hABCD;
        expect_sig("jmp_pc",     S_PC,     16'h1234);
        expect_sig("st_mwrite",  S_MWRITE, 16'h0001);
        expect_sig("st_r2m",     S_R2M,    16'h0002);
        expect_sig("st_rr1",     S_RR1,    16'h0005);
        expect_sig("st_aluop",   S_ALUOP,  16'h0006);
        expect_sig("st_result",  S_RESULT, 16'hABCD);
        expect_sig("st_write",   S_WRITE,  16'h0000);
        cyc();

        // pc 1235: LDI quarter 3, nibble A.
        imem_data = 9'b110_11_1010;
        expect_sig("ldi_pc",      S_PC,      16'h1235);
        expect_sig("ldi_imm",     S_IMM,     16'h0001);
        expect_sig("ldi_quarter", S_QUARTER, 16'h0003);
        expect_sig("ldi_rr1",     S_RR1,     16'h000A);
        expect_sig("ldi_write",   S_WRITE,   16'h0001);
        expect_sig("ldi_wr",      S_WR,      16'h0000);
        cyc();

        // pc 1236: LD into R1 from address in R3.
        imem_data = 9'b101_0_01_011;
        expect_sig("ld_m2r",   S_M2R,   16'h0001);
        expect_sig("ld_write", S_WRITE, 16'h0001);
        expect_sig("ld_wr",    S_WR,    16'h0001);
        expect_sig("ld_rr1",   S_RR1,   16'h0003);
        expect_sig("ld_mwr",   S_MWRITE,16'h0000);
        cyc();

        // pc 1237: MOV R0 -> R5.
        imem_data  = 9'b111_001_101;
        read_data0 = 16'h1111;
        expect_sig("mov_pc",     S_PC,     16'h1237);
        expect_sig("mov_move",   S_MOVE,   16'h0001);
        expect_sig("mov_write",  S_WRITE,  16'h0001);
        expect_sig("mov_rr0",    S_RR0,    16'h0000);
        expect_sig("mov_wr",     S_WR,     16'h0005);
        expect_sig("mov_aluop",  S_ALUOP,  16'h0005);
        expect_sig("mov_result", S_RESULT, 16'h1111);
        cyc();

        // pc 1238: JMP to FFFF.
        imem_data = 9'b111_100_000;
        target    = 16'hFFFF;
        cyc();

        // pc FFFF: NOP, next pc wraps to 0000.
        imem_data = 9'b111_111_000;
        expect_sig("nop_pc",     S_PC,     16'hFFFF);
        expect_sig("nop_branch", S_BRANCH, 16'h0000);
        expect_sig("nop_write",  S_WRITE,  16'h0000);
        expect_sig("nop_aluop",  S_ALUOP,  16'h0000);
        cyc();

        // pc 0000: AND.
        imem_data  = 9'b010_001_010;
        read_data0 = 16'hF0F0;
        read_data1 = 16'hFF00;
        expect_sig("wrap_pc",    S_PC,     16'h0000);
        expect_sig("and_result", S_RESULT, 16'hF000);
        cyc();

        // pc 0001: OR.
        imem_data  = 9'b011_001_010;
        read_data1 = 16'h0F00;
        expect_sig("or_result", S_RESULT, 16'hFFF0);
        cyc();

        // pc 0002: HALT, with init asserted (must be ignored).
        imem_data = 9'b111_000_000;
        init      = 1'b1;
        expect_sig("halt_pc",    S_PC,    16'h0002);
        expect_sig("halt_done",  S_DONE,  16'h0000);
        expect_sig("halt_write", S_WRITE, 16'h0000);
        cyc();

        // HALTED: done set, pc frozen, decode gated.
        imem_data = 9'b000_001_010;
        expect_quiet("halted");
        expect_sig("halted_done",  S_DONE,  16'h0001);
        expect_sig("halted_pc",    S_PC,    16'h0002);
        expect_sig("halted_start", S_START, 16'h0000);
        cyc();
        expect_sig("halted2_done", S_DONE, 16'h0001);
        expect_sig("halted2_pc",   S_PC,   16'h0002);
        cyc();

        // Asynchronous reset mid-cycle, checked before any rising edge.
        #2;
        rst_n = 1'b0;
        expect_sig("arst_done", S_DONE,  16'h0000);
        expect_sig("arst_pc",   S_PC,    16'h0000);
        expect_sig("arst_inst", S_INSTR, 16'h0000);
        cyc();
        init  = 1'b0;
        rst_n = 1'b1;
        cyc();
        expect_quiet("post_rst");
        expect_sig("post_rst_pc",    S_PC,    16'h0000);
        expect_sig("post_rst_done",  S_DONE,  16'h0000);
        expect_sig("post_rst_start", S_START, 16'h0000);

        // Let the monitor drain; anything left is a missed comparison.
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures += q.size();
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
